// File: rtl/cfi_log_queue_if.sv
// Checker-side stream of the CFI log queue: one record per valid/ready handshake.
// The record type belongs to the CFI filter and is passed in as a type parameter.
interface cfi_log_queue_if #(
    parameter type cfi_log_t = logic [63:0]
) ();
    logic     log_valid;
    logic     log_ready;
    cfi_log_t log_rec;

    modport master (
        output log_valid,
        output log_rec,
        input  log_ready
    );

    modport slave (
        input  log_valid,
        input  log_rec,
        output log_ready
    );
endinterface

// File: rtl/cfi_log_queue.sv
// Circular FIFO between the commit-stage CFI filter and the CFI checker.
// Compacts checked+committed records per cycle, pops one per handshake, counts overflow drops.
module cfi_log_queue #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter type         cfi_log_t       = logic [63:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  cfi_log_t                   log_i [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0] cfi_i,
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    output logic                       stall_o,
    cfi_log_queue_if.master            log_if,
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic [15:0]                drop_cnt_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    cfi_log_t               mem_q [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [15:0]            drop_q, drop_d;

    logic [NR_COMMIT_PORTS-1:0] req;
    logic [NR_COMMIT_PORTS-1:0] wr_en;
    logic [PtrW-1:0]            wr_addr [NR_COMMIT_PORTS];
    logic [CntW-1:0]            free;
    logic [CntW-1:0]            n_acc;
    logic [CntW-1:0]            n_drop;
    logic [16:0]                drop_sum;
    logic                       pop;

    // Free slots come from the registered count only; a same-cycle pop does not help pushes.
    always_comb begin
        req    = cfi_i & commit_ack_i;
        free   = CntW'(DEPTH) - count_q;
        n_acc  = '0;
        n_drop = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            wr_en[i]   = 1'b0;
            wr_addr[i] = wr_ptr_q + n_acc[PtrW-1:0];
            if (req[i]) begin
                if (n_acc < free) begin
                    wr_en[i] = 1'b1;
                    n_acc    = n_acc + 1'b1;
                end else begin
                    n_drop = n_drop + 1'b1;
                end
            end
        end
    end

    assign pop      = (count_q != '0) & log_if.log_ready;
    assign drop_sum = {1'b0, drop_q} + 17'(n_drop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + n_acc[PtrW-1:0];
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + n_acc - CntW'(pop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        // Flush discards this cycle's traffic and does not treat lost pushes as drops.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = drop_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (wr_en[i] && !flush_i && !rst_i) begin
                mem_q[wr_addr[i]] <= log_i[i];
            end
        end
    end

    assign log_if.log_valid = (count_q != '0);
    assign log_if.log_rec   = mem_q[rd_ptr_q];
    assign usage_o          = count_q;
    assign stall_o          = free < CntW'(NR_COMMIT_PORTS);
    assign drop_cnt_o       = drop_q;
endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed bench for cfi_log_queue: latency, ordering, compaction, overflow, wrap, flush, reset.
module tb_cfi_log_queue;
    typedef struct packed {
        logic [31:0] addr_pc;
        logic [31:0] target;
        logic [1:0]  kind;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       flush_i;
    rec_t       log_i [2];
    logic [1:0] cfi_i;
    logic [1:0] commit_ack_i;
    logic       stall_o;
    logic [3:0] usage_o;
    logic [15:0] drop_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    cfi_log_queue_if #(.cfi_log_t(rec_t)) q_if ();

    cfi_log_queue #(
        .NR_COMMIT_PORTS(2),
        .DEPTH          (8),
        .cfi_log_t      (rec_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .log_i       (log_i),
        .cfi_i       (cfi_i),
        .commit_ack_i(commit_ack_i),
        .stall_o     (stall_o),
        .log_if      (q_if),
        .usage_o     (usage_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [1:0] a,
                         input logic [31:0] p0, input logic [31:0] p1);
        cfi_i        = c;
        commit_ack_i = a;
        log_i[0]     = '{addr_pc: p0, target: ~p0, kind: 2'd1};
        log_i[1]     = '{addr_pc: p1, target: ~p1, kind: 2'd2};
    endtask

    task automatic idle();
        cfi_i        = 2'b00;
        commit_ack_i = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] want;
        int sent;
        int got;

        rst_i = 1'b1;
        flush_i = 1'b0;
        q_if.log_ready = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        step();
        step();
        rst_i = 1'b0;
        chk("rst_valid", 32'(q_if.log_valid), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_usage", 32'(usage_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);

        // Single record on port 0, checker not ready
        drive(2'b01, 2'b01, 32'h8000_0010, 32'h0);
        step();
        idle();
        chk("single_valid", 32'(q_if.log_valid), 32'd1);
        chk("single_pc", q_if.log_rec.addr_pc, 32'h8000_0010);
        chk("single_usage", 32'(usage_o), 32'd1);
        step();
        chk("hold_valid", 32'(q_if.log_valid), 32'd1);
        chk("hold_pc", q_if.log_rec.addr_pc, 32'h8000_0010);
        q_if.log_ready = 1'b1;
        step();
        chk("single_drain_usage", 32'(usage_o), 32'd0);
        chk("single_drain_valid", 32'(q_if.log_valid), 32'd0);

        // Both ports, ready held high
        drive(2'b11, 2'b11, 32'h0000_A000, 32'h0000_B000);
        step();
        idle();
        chk("pair_usage2", 32'(usage_o), 32'd2);
        chk("pair_first", q_if.log_rec.addr_pc, 32'h0000_A000);
        step();
        chk("pair_usage1", 32'(usage_o), 32'd1);
        chk("pair_second", q_if.log_rec.addr_pc, 32'h0000_B000);
        step();
        chk("pair_usage0", 32'(usage_o), 32'd0);
        chk("pair_empty", 32'(q_if.log_valid), 32'd0);

        // Compaction: port 0 flagged but not committing
        q_if.log_ready = 1'b0;
        drive(2'b11, 2'b10, 32'h0000_DEAD, 32'h0000_3000);
        step();
        idle();
        chk("compact_usage", 32'(usage_o), 32'd1);
        chk("compact_pc", q_if.log_rec.addr_pc, 32'h0000_3000);
        q_if.log_ready = 1'b1;
        step();
        chk("compact_drain", 32'(usage_o), 32'd0);
        q_if.log_ready = 1'b0;

        // Fill to full, overflow, push+pop at full
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 2'b11, 32'h4000 + 32'(2 * k), 32'h4001 + 32'(2 * k));
            step();
        end
        idle();
        chk("fill6_usage", 32'(usage_o), 32'd6);
        chk("fill6_stall", 32'(stall_o), 32'd0);
        drive(2'b01, 2'b01, 32'h4006, 32'h0);
        step();
        chk("fill7_usage", 32'(usage_o), 32'd7);
        chk("fill7_stall", 32'(stall_o), 32'd1);
        drive(2'b11, 2'b11, 32'h4007, 32'h4008);
        step();
        chk("full_usage", 32'(usage_o), 32'd8);
        chk("full_drop1", 32'(drop_cnt_o), 32'd1);
        chk("full_stall", 32'(stall_o), 32'd1);
        drive(2'b01, 2'b01, 32'h4009, 32'h0);
        q_if.log_ready = 1'b1;
        step();
        idle();
        chk("pushpop_usage", 32'(usage_o), 32'd7);
        chk("pushpop_drop2", 32'(drop_cnt_o), 32'd2);
        for (int k = 1; k < 8; k++) begin
            chk("fill_order", q_if.log_rec.addr_pc, 32'h4000 + 32'(k));
            step();
        end
        chk("fill_drained", 32'(usage_o), 32'd0);

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_clears_drop", 32'(drop_cnt_o), 32'd0);

        // Wrap-around with random interleave, stall honoured
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            idle();
            q_if.log_ready = 1'($urandom_range(0, 1));
            if (sent < 20 && !stall_o && $urandom_range(0, 2) != 0) begin
                if (sent < 19 && $urandom_range(0, 1) == 1) begin
                    drive(2'b11, 2'b11, 32'h5000 + 32'(sent), 32'h5001 + 32'(sent));
                    exp_q.push_back(32'h5000 + 32'(sent));
                    exp_q.push_back(32'h5001 + 32'(sent));
                    sent += 2;
                end else if ($urandom_range(0, 1) == 1) begin
                    drive(2'b10, 2'b10, 32'h0, 32'h5000 + 32'(sent));
                    exp_q.push_back(32'h5000 + 32'(sent));
                    sent++;
                end else begin
                    drive(2'b01, 2'b01, 32'h5000 + 32'(sent), 32'h0);
                    exp_q.push_back(32'h5000 + 32'(sent));
                    sent++;
                end
            end
            if (q_if.log_valid && q_if.log_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                chk("wrap_order", q_if.log_rec.addr_pc, want);
                got++;
            end
            step();
        end
        idle();
        q_if.log_ready = 1'b0;
        chk("wrap_count", 32'(got), 32'd20);
        chk("wrap_drop", 32'(drop_cnt_o), 32'd0);
        chk("wrap_usage", 32'(usage_o), 32'd0);

        // Flush with 5 entries and a same-cycle push, after creating drops
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b11, 32'h6000 + 32'(2 * k), 32'h6001 + 32'(2 * k));
            step();
        end
        drive(2'b11, 2'b11, 32'h6008, 32'h6009);
        step();
        idle();
        chk("pre_flush_drop", 32'(drop_cnt_o), 32'd2);
        q_if.log_ready = 1'b1;
        step();
        step();
        step();
        chk("pre_flush_usage", 32'(usage_o), 32'd5);
        chk("pre_flush_head", q_if.log_rec.addr_pc, 32'h6003);
        flush_i = 1'b1;
        drive(2'b11, 2'b11, 32'h6100, 32'h6101);
        step();
        flush_i = 1'b0;
        idle();
        q_if.log_ready = 1'b0;
        chk("flush_usage", 32'(usage_o), 32'd0);
        chk("flush_valid", 32'(q_if.log_valid), 32'd0);
        chk("flush_stall", 32'(stall_o), 32'd0);
        chk("flush_drop_kept", 32'(drop_cnt_o), 32'd2);
        drive(2'b01, 2'b01, 32'h7000, 32'h0);
        step();
        idle();
        chk("post_flush_usage", 32'(usage_o), 32'd1);
        chk("post_flush_pc", q_if.log_rec.addr_pc, 32'h7000);

        // Reset while full
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 2'b11, 32'h7001 + 32'(2 * k), 32'h7002 + 32'(2 * k));
            step();
        end
        drive(2'b01, 2'b01, 32'h7007, 32'h0);
        step();
        idle();
        chk("refill_usage", 32'(usage_o), 32'd8);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_full_valid", 32'(q_if.log_valid), 32'd0);
        chk("rst_full_usage", 32'(usage_o), 32'd0);
        chk("rst_full_stall", 32'(stall_o), 32'd0);
        chk("rst_full_drop", 32'(drop_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
